// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and instruction field positions.
package cpu_pkg;
   localparam int INSTR_W = 8;
   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 4;
   localparam int F2_MSB  = 3;
   localparam int F2_LSB  = 2;
   localparam int F3_MSB  = 1;
   localparam int F3_LSB  = 0;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module return_addr_stack
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_din,
   output logic [ADDR_W-1:0] o_dout,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_overflow,
   output logic              o_underflow
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = RAS_DEPTH[PTR_W:0];

   logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W:0]    r_depth;
   logic [PTR_W-1:0]  w_top_ptr;

   assign w_top_ptr = r_wr_ptr - 1'b1;
   assign o_empty   = (r_depth == '0);
   assign o_full    = (r_depth == FULL_CNT);
   assign o_dout    = o_empty ? '0 : r_mem[w_top_ptr];

   always_ff @(posedge i_clk) begin
      if (i_push && !i_reset)
         r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr    <= '0;
         r_depth     <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_push) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         if (o_full)
            o_overflow <= 1'b1;
         else
            r_depth <= r_depth + 1'b1;
      end else if (i_pop) begin
         if (o_empty) begin
            o_underflow <= 1'b1;
         end else begin
            r_wr_ptr <= w_top_ptr;
            r_depth  <= r_depth - 1'b1;
         end
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: ROM sequencing, IR field split, redirects and halt.
//   state | meaning
//   FETCH | ROM read strobed at pc
//   WAIT  | ROM data latched into IR, pc advances
//   ISSUE | IR valid, waiting for controller accept
//   HALT  | fetch stopped until reset
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   output logic [ADDR_W-1:0]  o_imem_addr,
   output logic               o_imem_rd_en,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   output logic [3:0]         o_ir_1,
   output logic [1:0]         o_ir_2,
   output logic [1:0]         o_ir_3,
   output logic               o_ir_valid,
   input  logic               i_ir_ready,
   input  logic               i_branch,
   input  logic [ADDR_W-1:0]  i_branch_target,
   input  logic               i_call,
   input  logic [ADDR_W-1:0]  i_call_target,
   input  logic               i_ret,
   input  logic               i_halt,
   output logic               o_halted,
   output logic               o_ras_overflow,
   output logic               o_ras_underflow
);
   fetch_state_t       r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
   logic [INSTR_W-1:0] r_ir;
   logic               w_rd_en;
   logic               w_push, w_pop;
   logic [ADDR_W-1:0]  w_ras_dout;
   logic               w_ras_empty, w_ras_full;

   return_addr_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_din       (r_pc),
      .o_dout      (w_ras_dout),
      .o_empty     (w_ras_empty),
      .o_full      (w_ras_full),
      .o_overflow  (o_ras_overflow),
      .o_underflow (o_ras_underflow)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_rd_en     = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (i_ir_ready) begin
               // halt outranks redirects; among redirects ret > call > branch
               if (i_halt) begin
                  w_state_nxt = ST_HALT;
               end else if (i_ret) begin
                  w_pop       = 1'b1;
                  w_pc_nxt    = w_ras_empty ? '0 : w_ras_dout;
                  w_state_nxt = ST_FETCH;
               end else if (i_call) begin
                  w_push      = 1'b1;
                  w_pc_nxt    = i_call_target;
                  w_state_nxt = ST_FETCH;
               end else if (i_branch) begin
                  w_pc_nxt    = i_branch_target;
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_rd_en     = 1'b1;
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (r_state == ST_WAIT)
            r_ir <= i_imem_rdata;
      end
   end

   assign o_imem_addr  = r_pc;
   assign o_imem_rd_en = w_rd_en & ~i_reset;
   assign o_ir_valid   = (r_state == ST_ISSUE);
   assign o_halted     = (r_state == ST_HALT);
   assign o_ir_1       = r_ir[OP_MSB:OP_LSB];
   assign o_ir_2       = r_ir[F2_MSB:F2_LSB];
   assign o_ir_3       = r_ir[F3_MSB:F3_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized redirects
// checked against a program-order model with a queue-based return stack.
module tb_instr_fetch_unit;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ready = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
   logic [7:0] btgt = '0, ctgt = '0;
   logic [7:0] imem_addr;
   logic       imem_rd_en;
   logic [7:0] imem_rdata = '0;
   logic [3:0] ir_1;
   logic [1:0] ir_2, ir_3;
   logic       ir_valid, halted, ras_ovf, ras_unf;

   logic [7:0] rom [256];

   int n_pass = 0, n_total = 0, n_fail = 0;

   logic [7:0] m_cur;
   logic [7:0] m_ras [$];
   bit         m_ovf, m_unf, m_redir;

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];

   instr_fetch_unit #(.ADDR_W(8), .RAS_DEPTH(4)) dut (
      .i_clk(clk), .i_reset(reset),
      .o_imem_addr(imem_addr), .o_imem_rd_en(imem_rd_en), .i_imem_rdata(imem_rdata),
      .o_ir_1(ir_1), .o_ir_2(ir_2), .o_ir_3(ir_3), .o_ir_valid(ir_valid),
      .i_ir_ready(ready), .i_branch(branch), .i_branch_target(btgt),
      .i_call(call), .i_call_target(ctgt), .i_ret(ret), .i_halt(halt),
      .o_halted(halted), .o_ras_overflow(ras_ovf), .o_ras_underflow(ras_unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      ready = 0; branch = 0; call = 0; ret = 0; halt = 0;
   endtask

   // Assert reset for one edge from whatever state the unit is in, then release.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      clear_ctrl();
      @(negedge clk);
      chk({tag, "_rden"}, imem_rd_en, 0);
      chk({tag, "_valid"}, ir_valid, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_ovf"}, ras_ovf, 0);
      chk({tag, "_unf"}, ras_unf, 0);
      chk({tag, "_ir"}, {ir_1, ir_2, ir_3}, 0);
      reset = 1'b0;
      #1;
      chk({tag, "_fetch_en"}, imem_rd_en, 1);
      chk({tag, "_fetch_addr"}, imem_addr, 0);
      m_cur = 8'h00; m_ras.delete(); m_ovf = 0; m_unf = 0; m_redir = 1;
   endtask

   // Wait for the next issued instruction; checks latency and IR fields against the ROM.
   task automatic wait_issue(input string tag);
      int n = 0;
      logic [7:0] w;
      while (!ir_valid && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, ir_valid, 1);
      if (ir_valid) begin
         w = rom[m_cur];
         chk({tag, "_latency"}, n, m_redir ? 2 : 1);
         chk({tag, "_ir1"}, ir_1, w[7:4]);
         chk({tag, "_ir2"}, ir_2, w[3:2]);
         chk({tag, "_ir3"}, ir_3, w[1:0]);
      end
   endtask

   task automatic stall(input int n);
      logic [7:0] w;
      w = rom[m_cur];
      clear_ctrl();
      for (int i = 0; i < n; i++) begin
         #1;
         chk("stall_rden", imem_rd_en, 0);
         chk("stall_valid", ir_valid, 1);
         chk("stall_ir", {ir_1, ir_2, ir_3}, w);
         @(negedge clk);
      end
   endtask

   // Accept the issued instruction with the given controls and advance the model.
   task automatic accept(input bit h, input bit r, input bit c, input bit b,
                         input logic [7:0] ct, input logic [7:0] bt);
      logic [7:0] nx, seq;
      bit redir;
      ready = 1; halt = h; ret = r; call = c; branch = b; ctgt = ct; btgt = bt;
      #1;
      seq   = m_cur + 8'd1;
      redir = !h && (r || c || b);
      chk("acc_rden", imem_rd_en, (!h && !redir));
      if (!h && !redir) chk("acc_addr", imem_addr, seq);
      nx = seq;
      if (h) begin
         nx = m_cur;
      end else if (r) begin
         if (m_ras.size() == 0) begin
            nx = 8'h00;
            m_unf = 1;
         end else begin
            nx = m_ras.pop_back();
         end
      end else if (c) begin
         m_ras.push_back(seq);
         if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
         end
         nx = ct;
      end else if (b) begin
         nx = bt;
      end
      @(negedge clk);
      clear_ctrl();
      chk("acc_ovf", ras_ovf, m_ovf);
      chk("acc_unf", ras_unf, m_unf);
      if (h) begin
         chk("halt_halted", halted, 1);
         chk("halt_valid", ir_valid, 0);
         chk("halt_rden", imem_rd_en, 0);
      end else if (redir) begin
         chk("redir_rden", imem_rd_en, 1);
         chk("redir_addr", imem_addr, nx);
      end
      m_cur = nx;
      m_redir = redir;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

      // single instruction after reset
      rom[0] = 8'hFB;
      @(negedge clk);
      do_reset("t1_rst");
      wait_issue("t1");
      chk("t1_op", ir_1, 4'hF);
      chk("t1_f2", ir_2, 2'b10);
      chk("t1_f3", ir_3, 2'b11);

      // sequential stream, then a stall
      rom[0] = 8'h91; rom[1] = 8'hB8; rom[2] = 8'hF2; rom[3] = 8'h37;
      do_reset("t2_rst");
      wait_issue("t2_i0");
      chk("t2_op0", ir_1, 4'h9);
      accept(0, 0, 0, 0, 8'h00, 8'h00);
      wait_issue("t2_i1");
      chk("t2_op1", ir_1, 4'hB);
      accept(0, 0, 0, 0, 8'h00, 8'h00);
      wait_issue("t2_i2");
      chk("t2_op2", ir_1, 4'hF);
      stall(5);
      accept(0, 0, 0, 0, 8'h00, 8'h00);

      // branch from pc 3, then pc wrap at 8'hFF
      wait_issue("t4_i3");
      accept(0, 0, 0, 1, 8'h00, 8'h40);
      chk("t4_target", imem_addr, 8'h40);
      wait_issue("t4_i40");
      accept(0, 0, 0, 1, 8'h00, 8'hFF);
      wait_issue("wrap_iff");
      accept(0, 0, 0, 0, 8'h00, 8'h00);
      chk("wrap_addr", m_cur, 8'h00);
      wait_issue("wrap_i0");

      // call from 5 to 8'h20, return resumes at 6
      do_reset("t5_rst");
      for (int k = 0; k < 5; k++) begin
         wait_issue("t5_seq");
         accept(0, 0, 0, 0, 8'h00, 8'h00);
      end
      wait_issue("t5_i5");
      accept(0, 0, 1, 0, 8'h20, 8'h00);
      chk("t5_call_addr", imem_addr, 8'h20);
      wait_issue("t5_i20");
      accept(0, 1, 0, 0, 8'h00, 8'h00);
      chk("t5_ret_addr", imem_addr, 8'h06);
      wait_issue("t5_i6");

      // RAS overflow and underflow
      do_reset("t6_rst");
      for (int k = 0; k < 5; k++) begin
         wait_issue("t6_call");
         accept(0, 0, 1, 0, 8'((k + 1) * 16), 8'h00);
         chk("t6_ovf", ras_ovf, (k == 4));
      end
      for (int k = 0; k < 5; k++) begin
         wait_issue("t6_ret");
         accept(0, 1, 0, 1, 8'h00, 8'hEE);
         chk("t6_unf", ras_unf, (k == 4));
      end
      chk("t6_last_addr", imem_addr, 8'h00);

      // reset from WAIT clears sticky flags
      wait_issue("t7_pre");
      accept(0, 0, 0, 0, 8'h00, 8'h00);
      do_reset("t7_wait_rst");

      // randomized redirects against the model
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      for (int k = 0; k < 80; k++) begin
         wait_issue("rnd");
         if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
         accept(0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 4) == 0), 8'($urandom), 8'($urandom));
      end

      // halt ignores later controls and only reset exits
      wait_issue("halt_pre");
      accept(1, 1, 1, 1, 8'h11, 8'h22);
      for (int k = 0; k < 3; k++) begin
         ready = 1; branch = 1; btgt = 8'h55;
         @(negedge clk);
         chk("halt_hold", halted, 1);
         chk("halt_hold_rden", imem_rd_en, 0);
         chk("halt_hold_valid", ir_valid, 0);
      end
      do_reset("t7_halt_rst");
      wait_issue("post_halt");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
